// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: captures a window of ADC words around a trigger in a
// circular buffer, then streams the window out over a valid/ready port.
//
// Stream handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once raised, out_valid stays high with out_data and
// out_last held stable until that transfer happens; only abort or reset may
// drop it early.
module adc_trigger_capture #(
  parameter int PARALLEL_SAMPLES = 16,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int DEPTH            = 1024,
  localparam int DATA_W   = PARALLEL_SAMPLES * SAMPLE_WIDTH,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int LEN_BITS = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [2*LEN_BITS-1:0] config_data,
  input  logic                  config_valid,
  output logic                  config_ready,
  output logic                  config_error,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  early_trigger,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                rst_meta, rst_n;
  logic [LEN_BITS-1:0] pre_len, post_len, fill_cnt, post_cnt, rd_left;
  logic [PTR_BITS-1:0] wr_ptr, rd_addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata, skid_data;
  logic                rdata_valid, rdata_last, skid_valid, skid_last;

  logic [LEN_BITS-1:0] cfg_pre, cfg_post_raw, cfg_post;
  logic [LEN_BITS:0]   cfg_sum;
  logic                cfg_take, cfg_bad;
  logic                adc_we, fill_full, trig_hit, cap_done, pop, rd_issue;
  logic [1:0]          occ;

  assign state_dbg = state;

  // Reset assertion is immediate; deassertion is retimed through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // Config decode: zero post length means one word, window must fit the buffer.
  assign cfg_pre      = config_data[LEN_BITS-1:0];
  assign cfg_post_raw = config_data[2*LEN_BITS-1:LEN_BITS];
  assign cfg_post     = (cfg_post_raw == '0) ? LEN_BITS'(1) : cfg_post_raw;
  assign cfg_sum      = {1'b0, cfg_pre} + {1'b0, cfg_post};
  assign cfg_bad      = cfg_sum > (LEN_BITS + 1)'(DEPTH);
  assign cfg_take     = config_valid && config_ready && !abort;

  // Capture qualifiers; the trigger only counts on a valid ADC word.
  assign adc_we    = adc_valid && !abort && (state == ARMED || state == CAPTURE);
  assign fill_full = (fill_cnt == pre_len);
  assign trig_hit  = adc_we && trigger && (state == ARMED);
  assign cap_done  = adc_we && (state == CAPTURE) && (post_cnt + LEN_BITS'(1) == post_len);

  // Reads are issued only while the in-flight word plus the skid stage hold
  // fewer than two words after this cycle's pop, so the skid never overflows.
  assign pop      = out_valid && out_ready;
  assign occ      = 2'(out_valid) + 2'(skid_valid) + 2'(rdata_valid) - 2'(pop);
  assign rd_issue = (state == READOUT) && !abort && (rd_left != '0) && (occ < 2'd2);

  // Next-state selection; abort overrides everything.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm) state_nxt = ARMED;
        ARMED:   if (trig_hit && fill_full)
                   state_nxt = (post_len == LEN_BITS'(1)) ? READOUT : CAPTURE;
        CAPTURE: if (cap_done) state_nxt = READOUT;
        READOUT: if (pop && out_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM, configuration, capture counters and read address generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      config_ready  <= 1'b1;
      config_error  <= 1'b0;
      early_trigger <= 1'b0;
      pre_len       <= '0;
      post_len      <= LEN_BITS'(1);
      fill_cnt      <= '0;
      post_cnt      <= '0;
      rd_left       <= '0;
      wr_ptr        <= '0;
      rd_addr       <= '0;
      rdata_valid   <= 1'b0;
      rdata_last    <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      config_ready <= (state_nxt == IDLE);
      config_error <= cfg_take && cfg_bad;
      if (cfg_take && !cfg_bad) begin
        pre_len  <= cfg_pre;
        post_len <= cfg_post;
      end
      if (state == IDLE && arm && !abort) begin
        fill_cnt      <= '0;
        early_trigger <= 1'b0;
      end
      if (adc_we) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (adc_we && state == ARMED && !fill_full) fill_cnt <= fill_cnt + LEN_BITS'(1);
      if (trig_hit) begin
        if (fill_full) begin
          rd_addr  <= wr_ptr - pre_len[PTR_BITS-1:0];
          rd_left  <= pre_len + post_len;
          post_cnt <= LEN_BITS'(1);
        end else begin
          early_trigger <= 1'b1;
        end
      end
      if (adc_we && state == CAPTURE) post_cnt <= post_cnt + LEN_BITS'(1);
      if (rd_issue) begin
        rd_addr <= rd_addr + PTR_BITS'(1);
        rd_left <= rd_left - LEN_BITS'(1);
      end
      if (abort) rd_left <= '0;
      rdata_valid <= rd_issue;
      rdata_last  <= rd_issue && (rd_left == LEN_BITS'(1));
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    if (adc_we) mem[wr_ptr] <= adc_data;
  end

  // Sample buffer registered read port.
  always_ff @(posedge clk) begin
    if (rd_issue) rdata <= mem[rd_addr];
  end

  // Two-entry output skid: output register first, overflow word in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
    end else if (abort) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        out_valid  <= 1'b1;
        skid_valid <= rdata_valid;
        if (rdata_valid) begin
          skid_data <= rdata;
          skid_last <= rdata_last;
        end
      end else begin
        out_valid <= rdata_valid;
        out_last  <= rdata_valid && rdata_last;
        if (rdata_valid) out_data <= rdata;
      end
    end else if (rdata_valid) begin
      skid_data  <= rdata;
      skid_last  <= rdata_last;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Bench for adc_trigger_capture: small buffer instance, counting ADC data,
// scoreboard of expected {last, data} words popped on every stream transfer.
module tb_adc_trigger_capture;

  localparam int PS       = 2;
  localparam int SW       = 8;
  localparam int DEPTH    = 16;
  localparam int W        = PS * SW;
  localparam int LEN_BITS = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [W-1:0]          adc_data = '0;
  logic                  adc_valid = 1'b0;
  logic                  trigger = 1'b0;
  logic                  arm = 1'b0;
  logic                  abort = 1'b0;
  logic [2*LEN_BITS-1:0] config_data = '0;
  logic                  config_valid = 1'b0;
  logic                  config_ready, config_error;
  logic [W-1:0]          out_data;
  logic                  out_valid, out_last;
  logic                  out_ready;
  logic                  busy, early_trigger;
  logic [1:0]            state_dbg;

  int          checks = 0;
  int          failures = 0;
  logic [W:0]  exp_q[$];
  int          hs_cnt = 0;
  int          rdy_mode = 0;
  int          adc_cnt = 1;
  int          wr_model = 0;
  int          m_pre = 0;
  int          m_post = 1;
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [W:0]  prev_word = '0;
  logic [W:0]  mon_exp;
  logic        bench_done = 1'b0;

  adc_trigger_capture #(
    .PARALLEL_SAMPLES(PS),
    .SAMPLE_WIDTH(SW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .trigger(trigger),
    .arm(arm),
    .abort(abort),
    .config_data(config_data),
    .config_valid(config_valid),
    .config_ready(config_ready),
    .config_error(config_error),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy),
    .early_trigger(early_trigger),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // downstream ready: 0 = held low, 1 = held high, 2 = random 30% duty
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  // stream monitor: scoreboard pop on transfer, stability while stalled
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'({out_last, out_data}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("sb_word", 32'({out_last, out_data}), 32'(mon_exp));
        end
        hs_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      prev_abort = abort;
    end
  end

  task automatic set_cfg(input int pre, input int post);
    int  post_eff;
    bit  bad;
    post_eff = (post == 0) ? 1 : post;
    bad = (pre + post_eff) > DEPTH;
    config_data  = {LEN_BITS'(post), LEN_BITS'(pre)};
    config_valid = 1'b1;
    tick();
    config_valid = 1'b0;
    check("cfg_err", 32'(config_error), 32'(bad));
    tick();
    check("cfg_err_pulse", 32'(config_error), 0);
    if (!bad) begin
      m_pre  = pre;
      m_post = post_eff;
    end
  endtask

  task automatic send_words(input int n_before, input int n_post, input int early_idx,
                            input bit gaps, output int trig_val);
    trig_val = 0;
    for (int i = 0; i < n_before + n_post; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          adc_valid = 1'b0;
          trigger   = 1'($urandom_range(0, 1));
          tick();
        end
      end
      adc_valid = 1'b1;
      adc_data  = W'(adc_cnt);
      trigger   = (i == n_before) || (i == early_idx);
      if (i == n_before) trig_val = adc_cnt;
      adc_cnt++;
      tick();
    end
    adc_valid = 1'b0;
    trigger   = 1'b0;
    wr_model  = (wr_model + n_before + n_post) % DEPTH;
  endtask

  task automatic run_shot(input int n_before, input int early_idx, input bit gaps,
                          input bit cfg_poke);
    int tv;
    int len;
    len = m_pre + m_post;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state", 32'(state_dbg), 1);
    check("arm_busy", 32'(busy), 1);
    check("arm_cfg_ready", 32'(config_ready), 0);
    check("arm_early_clr", 32'(early_trigger), 0);
    if (cfg_poke) begin
      config_data  = {LEN_BITS'(2), LEN_BITS'(2)};
      config_valid = 1'b1;
      tick();
      config_valid = 1'b0;
      check("poke_no_err", 32'(config_error), 0);
      check("poke_state", 32'(state_dbg), 1);
    end
    send_words(n_before, m_post, early_idx, gaps, tv);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({(k == len - 1), W'(tv - m_pre + k)});
    end
    check("rd_state", 32'(state_dbg), 3);
    check("lat0", 32'(out_valid), 0);
    tick();
    check("lat1", 32'(out_valid), 0);
    tick();
    check("lat2", 32'(out_valid), 1);
  endtask

  task automatic stream_check(input int len);
    for (int i = 0; i < len; i++) begin
      check("no_bubble", 32'(out_valid), 1);
      tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_cfg_ready", 32'(config_ready), 1);
  endtask

  // global time bound
  initial begin
    #400000;
    check("global_timeout", 32'(bench_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int tv;
    int nb;
    int h0;

    // reset values
    repeat (3) tick();
    check("rst_cfg_ready", 32'(config_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_state", 32'(state_dbg), 0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("rel_cfg_ready", 32'(config_ready), 1);

    // basic window
    rdy_mode = 1;
    set_cfg(4, 4);
    run_shot(10, -1, 1'b0, 1'b0);
    stream_check(8);
    drain();

    // early trigger, full-buffer window
    set_cfg(8, 8);
    run_shot(20, 2, 1'b0, 1'b0);
    check("early_set", 32'(early_trigger), 1);
    stream_check(16);
    drain();

    // zero post length behaves as one
    set_cfg(3, 0);
    run_shot(5, -1, 1'b0, 1'b0);
    stream_check(4);
    drain();

    // wrap-around: trigger word lands at buffer address 13
    set_cfg(6, 10);
    nb = (13 - wr_model + DEPTH) % DEPTH;
    if (nb < 6) nb += DEPTH;
    run_shot(nb, -1, 1'b1, 1'b0);
    stream_check(16);
    drain();

    // random backpressure
    set_cfg(5, 11);
    rdy_mode = 2;
    run_shot(9, -1, 1'b1, 1'b0);
    drain();

    // rejected config and config poke while armed keep old window
    set_cfg(8, 12);
    run_shot(7, -1, 1'b0, 1'b1);
    drain();

    // abort during readout after three words
    set_cfg(4, 8);
    rdy_mode = 0;
    run_shot(6, -1, 1'b0, 1'b0);
    h0 = hs_cnt;
    rdy_mode = 1;
    repeat (3) tick();
    rdy_mode = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_hs", 32'(hs_cnt - h0), 3);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_last", 32'(out_last), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_state", 32'(state_dbg), 0);
    exp_q.delete();
    rdy_mode = 1;
    repeat (3) tick();

    // asynchronous reset mid-capture
    arm = 1'b1;
    tick();
    arm = 1'b0;
    send_words(6, 3, 1, 1'b0, tv);
    check("cap_state", 32'(state_dbg), 2);
    check("cap_early", 32'(early_trigger), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_last", 32'(out_last), 0);
    check("arst_out_data", 32'(out_data), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_cfg_err", 32'(config_error), 0);
    check("arst_early", 32'(early_trigger), 0);
    check("arst_cfg_ready", 32'(config_ready), 1);
    check("arst_state", 32'(state_dbg), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    wr_model = 0;
    m_pre = 0;
    m_post = 1;
    exp_q.delete();

    // re-armed capture on reset config: single trigger word
    run_shot(2, -1, 1'b0, 1'b0);
    stream_check(1);
    drain();

    // final mixed shot
    set_cfg(7, 9);
    rdy_mode = 2;
    run_shot(12, 3, 1'b1, 1'b0);
    check("early_set2", 32'(early_trigger), 1);
    drain();

    bench_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
